npc_lsu: RTL and testbench

//  Load/store initiator for the NPC core. It accepts one load or store per transaction from EXU
//  and drives the data-memory request port: word-aligned address, byte write mask and

---
 rtl/npc_lsu_if.sv | 46 ++++
 rtl/npc_lsu.sv | 152 +++++++++++++++
 tb/tb_npc_lsu.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/npc_lsu_if.sv
// npc_lsu_if: bus bundle between the LSU, its requester (EXU/WBU) and data memory.
//   req_*  : EXU -> LSU request (valid/ready, wen, addr, wdata, size, sext)
//   resp_* : LSU -> WBU response (valid/ready, rdata, err)
//   mem_*  : LSU -> memory request and memory -> LSU read data / ack
// Modports:
//   slave  : the LSU's view
//   master : the environment's view (EXU + memory model)
interface npc_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_sext;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata, req_size, req_sext,
    output req_ready,
    output resp_valid, resp_rdata, resp_err,
    input  resp_ready,
    output mem_valid, mem_wen, mem_addr, mem_wdata, mem_wmask,
    input  mem_ready, mem_rvalid, mem_rdata
  );

  modport master (
    output req_valid, req_wen, req_addr, req_wdata, req_size, req_sext,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_err,
    output resp_ready,
    input  mem_valid, mem_wen, mem_addr, mem_wdata, mem_wmask,
    output mem_ready, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/npc_lsu.sv
// npc_lsu: load/store initiator for the NPC core.
// Accepts one load/store from EXU, issues a word-aligned memory request with a
// byte mask and lane-shifted write data, then returns the lane-aligned,
// sign/zero-extended load data (or 0 for stores) to WBU.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : npc_lsu_if.slave (req_*, resp_*, mem_* groups)
// Parameters:
//   TIMEOUT_W : WAIT-state watchdog width; timeout after 2**TIMEOUT_W-1 WAIT
//               cycles without mem_rvalid.
// Build option:
//   LSU_MISALIGN_TRAP_EN : when defined, misaligned half/word accesses skip
//                          memory and respond with resp_err=1.
module npc_lsu #(
  parameter int unsigned TIMEOUT_W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  npc_lsu_if.slave   bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]           state;
  logic                 wen_q;
  logic [31:0]          addr_q;
  logic [31:0]          wdata_q;
  logic [1:0]           size_q;
  logic                 sext_q;
  logic [31:0]          rdata_q;
  logic                 err_q;
  logic [TIMEOUT_W-1:0] wd_q;

  logic [TIMEOUT_W-1:0] wd_inc;
  logic [1:0]           off;
  logic [3:0]           mask4;
  logic [31:0]          wdata_sh;
  logic [31:0]          lane;
  logic [31:0]          load_ext;
  logic                 in_req;
  logic                 in_resp;
  logic                 misalign;

  assign off     = addr_q[1:0];
  assign in_req  = (state == S_REQ);
  assign in_resp = (state == S_RESP);
  assign wd_inc  = wd_q + 1'b1;

  // Size 2'b11 is treated as a word, so size_q[1] alone selects word behaviour.
  // Shifts are evaluated in 4-bit context: lanes past byte 3 are dropped.
  always_comb begin
    mask4 = 4'b0000;
    if (size_q[1])          mask4 = 4'b1111;
    else if (size_q[0])     mask4 = 4'b0011 << off;
    else                    mask4 = 4'b0001 << off;
  end

  assign wdata_sh = wdata_q << {off, 3'b000};
  assign lane     = bus.mem_rdata >> {off, 3'b000};

  always_comb begin
    load_ext = lane;
    case (size_q)
      2'b00:   load_ext = sext_q ? {{24{lane[7]}}, lane[7:0]}
                                 : {24'h000000, lane[7:0]};
      2'b01:   load_ext = sext_q ? {{16{lane[15]}}, lane[15:0]}
                                 : {16'h0000, lane[15:0]};
      default: load_ext = lane;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                    (bus.req_size[1] && (bus.req_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      sext_q  <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      wd_q    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            wen_q   <= bus.req_wen;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            size_q  <= bus.req_size;
            sext_q  <= bus.req_sext;
            rdata_q <= '0;
            wd_q    <= '0;
            if (misalign) begin
              err_q <= 1'b1;
              state <= S_RESP;
            end else begin
              err_q <= 1'b0;
              state <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (bus.mem_ready) begin
            wd_q  <= '0;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          // Ack wins over a timeout landing in the same cycle.
          if (bus.mem_rvalid) begin
            rdata_q <= wen_q ? '0 : load_ext;
            err_q   <= 1'b0;
            state   <= S_RESP;
          end else if (wd_inc == '1) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
            state   <= S_RESP;
          end else begin
            wd_q <= wd_inc;
          end
        end
        default: begin
          if (bus.resp_ready) state <= S_IDLE;
        end
      endcase
    end
  end

  // Outputs are gated by state so nothing leaks outside its phase.
  assign bus.req_ready  = rst_n & (state == S_IDLE);
  assign bus.mem_valid  = in_req;
  assign bus.mem_wen    = in_req & wen_q;
  assign bus.mem_addr   = in_req ? {addr_q[31:2], 2'b00} : '0;
  assign bus.mem_wdata  = (in_req && wen_q) ? wdata_sh : '0;
  assign bus.mem_wmask  = (in_req && wen_q) ? {4'b0000, mask4} : '0;
  assign bus.resp_valid = in_resp;
  assign bus.resp_rdata = in_resp ? rdata_q : '0;
  assign bus.resp_err   = in_resp & err_q;

endmodule

// File: tb/tb_npc_lsu.sv
module tb_npc_lsu;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  npc_lsu_if bus ();

  npc_lsu #(.TIMEOUT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Drive one transaction with immediate mem_ready / mem_rvalid / resp_ready
  // and return what was observed on the memory and response sides.
  task automatic do_txn(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [1:0] size, input logic sext, input logic [31:0] mrd,
                        output logic mv, output logic mw, output logic [31:0] ma,
                        output logic [31:0] md, output logic [7:0] mk,
                        output logic rv, output logic re, output logic [31:0] rd);
    bus.req_valid = 1'b1; bus.req_wen = wen; bus.req_addr = addr;
    bus.req_wdata = wdata; bus.req_size = size; bus.req_sext = sext;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    mv = bus.mem_valid; mw = bus.mem_wen; ma = bus.mem_addr;
    md = bus.mem_wdata; mk = bus.mem_wmask;
    if (bus.mem_valid) begin
      bus.mem_ready = 1'b1;
      @(posedge clk); #1;
      bus.mem_ready = 1'b0;
      bus.mem_rvalid = 1'b1; bus.mem_rdata = mrd;
      @(posedge clk); #1;
      bus.mem_rvalid = 1'b0;
    end
    rv = bus.resp_valid; re = bus.resp_err; rd = bus.resp_rdata;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({bus.req_ready, bus.mem_valid, bus.resp_valid, bus.mem_wmask, bus.mem_addr} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got rr=%b mv=%b rv=%b mk=%h ma=%h exp all 0",
               bus.req_ready, bus.mem_valid, bus.resp_valid, bus.mem_wmask, bus.mem_addr);
    end
    @(posedge clk); #1; rst_n = 1'b1; #1;
    checks++;
    if (bus.req_ready !== 1'b1) begin
      failures++; $display("FAIL reset_req_ready got %b exp 1", bus.req_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_loads();
    logic mv, mw, rv, re; logic [31:0] ma, md, rd; logic [7:0] mk;
    // lb, sign-extended, top lane
    do_txn(1'b0, 32'h8000_0003, 32'h0, 2'b00, 1'b1, 32'h8012_3456, mv, mw, ma, md, mk, rv, re, rd);
    checks++;
    if ({mv, mw, ma, mk} !== {1'b1, 1'b0, 32'h8000_0000, 8'h00}) begin
      failures++; $display("FAIL lb_mem got mv=%b mw=%b ma=%h mk=%h exp 1 0 80000000 00", mv, mw, ma, mk);
    end
    checks++;
    if ({rv, re, rd} !== {1'b1, 1'b0, 32'hFFFF_FF80}) begin
      failures++; $display("FAIL lb_resp got rv=%b re=%b rd=%h exp 1 0 ffffff80", rv, re, rd);
    end
    // lhu upper half
    do_txn(1'b0, 32'h8000_0002, 32'h0, 2'b01, 1'b0, 32'hBEEF_1234, mv, mw, ma, md, mk, rv, re, rd);
    checks++;
    if ({rv, re, rd} !== {1'b1, 1'b0, 32'h0000_BEEF}) begin
      failures++; $display("FAIL lhu_resp got rv=%b re=%b rd=%h exp 1 0 0000beef", rv, re, rd);
    end
    // lh sign-extended lane 0
    do_txn(1'b0, 32'h8000_0000, 32'h0, 2'b01, 1'b1, 32'h0000_8001, mv, mw, ma, md, mk, rv, re, rd);
    checks++;
    if (rd !== 32'hFFFF_8001) begin
      failures++; $display("FAIL lh_sext got %h exp ffff8001", rd);
    end
    // lbu lane 1, zero-extended despite bit 7 set
    do_txn(1'b0, 32'h8000_0005, 32'h0, 2'b00, 1'b0, 32'h0000_9A00, mv, mw, ma, md, mk, rv, re, rd);
    checks++;
    if ({ma, rd} !== {32'h8000_0004, 32'h0000_009A}) begin
      failures++; $display("FAIL lbu_lane1 got ma=%h rd=%h exp 80000004 0000009a", ma, rd);
    end
    // lw aligned
    do_txn(1'b0, 32'h8000_0010, 32'h0, 2'b10, 1'b1, 32'h8765_4321, mv, mw, ma, md, mk, rv, re, rd);
    checks++;
    if (rd !== 32'h8765_4321) begin
      failures++; $display("FAIL lw_aligned got %h exp 87654321", rd);
    end
  endtask

  task automatic test_stores();
    logic mv, mw, rv, re; logic [31:0] ma, md, rd; logic [7:0] mk;
    do_txn(1'b1, 32'h8000_0001, 32'h0000_00AB, 2'b00, 1'b0, 32'hFFFF_FFFF, mv, mw, ma, md, mk, rv, re, rd);
    checks++;
    if ({mv, mw, ma, md, mk} !== {1'b1, 1'b1, 32'h8000_0000, 32'h0000_AB00, 8'h02}) begin
      failures++; $display("FAIL sb_mem got mv=%b mw=%b ma=%h md=%h mk=%h exp 1 1 80000000 0000ab00 02",
                           mv, mw, ma, md, mk);
    end
    checks++;
    if ({rv, re, rd} !== {1'b1, 1'b0, 32'h0}) begin
      failures++; $display("FAIL sb_resp got rv=%b re=%b rd=%h exp 1 0 00000000", rv, re, rd);
    end
    do_txn(1'b1, 32'h8000_0008, 32'hDEAD_BEEF, 2'b10, 1'b0, 32'h0, mv, mw, ma, md, mk, rv, re, rd);
    checks++;
    if ({ma, md, mk} !== {32'h8000_0008, 32'hDEAD_BEEF, 8'h0F}) begin
      failures++; $display("FAIL sw_mem got ma=%h md=%h mk=%h exp 80000008 deadbeef 0f", ma, md, mk);
    end
    do_txn(1'b1, 32'h8000_0006, 32'h0000_5678, 2'b01, 1'b0, 32'h0, mv, mw, ma, md, mk, rv, re, rd);
    checks++;
    if ({ma, md, mk} !== {32'h8000_0004, 32'h5678_0000, 8'h0C}) begin
      failures++; $display("FAIL sh_off2 got ma=%h md=%h mk=%h exp 80000004 56780000 0c", ma, md, mk);
    end
  endtask

  task automatic test_misalign();
    logic mv, mw, rv, re; logic [31:0] ma, md, rd; logic [7:0] mk;
    do_txn(1'b0, 32'h8000_0002, 32'h0, 2'b10, 1'b0, 32'h1122_3344, mv, mw, ma, md, mk, rv, re, rd);
`ifdef LSU_MISALIGN_TRAP_EN
    checks++;
    if ({mv, rv, re, rd} !== {1'b0, 1'b1, 1'b1, 32'h0}) begin
      failures++; $display("FAIL lw_misalign_trap got mv=%b rv=%b re=%b rd=%h exp 0 1 1 0", mv, rv, re, rd);
    end
    do_txn(1'b1, 32'h8000_0003, 32'h0000_1234, 2'b01, 1'b0, 32'h0, mv, mw, ma, md, mk, rv, re, rd);
    checks++;
    if ({mv, rv, re} !== {1'b0, 1'b1, 1'b1}) begin
      failures++; $display("FAIL sh_misalign_trap got mv=%b rv=%b re=%b exp 0 1 1", mv, rv, re);
    end
`else
    checks++;
    if ({mv, ma, mk, rv, re, rd} !== {1'b1, 32'h8000_0000, 8'h00, 1'b1, 1'b0, 32'h0000_1122}) begin
      failures++; $display("FAIL lw_misalign got mv=%b ma=%h mk=%h rv=%b re=%b rd=%h exp 1 80000000 00 1 0 00001122",
                           mv, ma, mk, rv, re, rd);
    end
    do_txn(1'b1, 32'h8000_0003, 32'h0000_1234, 2'b01, 1'b0, 32'h0, mv, mw, ma, md, mk, rv, re, rd);
    checks++;
    if ({mv, md, mk, re} !== {1'b1, 32'h3400_0000, 8'h08, 1'b0}) begin
      failures++; $display("FAIL sh_off3_trunc got mv=%b md=%h mk=%h re=%b exp 1 34000000 08 0", mv, md, mk, re);
    end
    do_txn(1'b0, 32'h8000_0003, 32'h0, 2'b01, 1'b1, 32'hAB00_0000, mv, mw, ma, md, mk, rv, re, rd);
    checks++;
    if (rd !== 32'h0000_00AB) begin
      failures++; $display("FAIL lh_off3_trunc got %h exp 000000ab", rd);
    end
`endif
  endtask

  task automatic test_back_pressure();
    logic [31:0] ref_addr;
    bus.req_valid = 1'b1; bus.req_wen = 1'b0; bus.req_addr = 32'h8000_0022;
    bus.req_wdata = 32'h0; bus.req_size = 2'b01; bus.req_sext = 1'b1;
    bus.resp_ready = 1'b0;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    ref_addr = 32'h8000_0020;
    for (int i = 0; i < 6; i++) begin
      if (i == 5) bus.mem_ready = 1'b1;
      checks++;
      if ({bus.mem_valid, bus.mem_wen, bus.mem_addr, bus.mem_wmask, bus.req_ready} !==
          {1'b1, 1'b0, ref_addr, 8'h00, 1'b0}) begin
        failures++; $display("FAIL stall_req[%0d] got mv=%b mw=%b ma=%h mk=%h rr=%b exp 1 0 %h 00 0",
                             i, bus.mem_valid, bus.mem_wen, bus.mem_addr, bus.mem_wmask, bus.req_ready, ref_addr);
      end
      @(posedge clk); #1;
    end
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({bus.mem_valid, bus.resp_valid, bus.req_ready} !== 3'b000) begin
        failures++; $display("FAIL stall_wait[%0d] got mv=%b rv=%b rr=%b exp 0 0 0",
                             i, bus.mem_valid, bus.resp_valid, bus.req_ready);
      end
      @(posedge clk); #1;
    end
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h8765_0000;
    @(posedge clk); #1;
    bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) bus.resp_ready = 1'b1;
      checks++;
      if ({bus.resp_valid, bus.resp_err, bus.resp_rdata, bus.req_ready, bus.mem_valid} !==
          {1'b1, 1'b0, 32'hFFFF_8765, 1'b0, 1'b0}) begin
        failures++; $display("FAIL stall_resp[%0d] got rv=%b re=%b rd=%h rr=%b mv=%b exp 1 0 ffff8765 0 0",
                             i, bus.resp_valid, bus.resp_err, bus.resp_rdata, bus.req_ready, bus.mem_valid);
      end
      @(posedge clk); #1;
    end
    checks++;
    if ({bus.resp_valid, bus.req_ready} !== 2'b01) begin
      failures++; $display("FAIL stall_release got rv=%b rr=%b exp 0 1", bus.resp_valid, bus.req_ready);
    end
  endtask

  task automatic test_reset_in_wait();
    logic mv, mw, rv, re; logic [31:0] ma, md, rd; logic [7:0] mk;
    bus.req_valid = 1'b1; bus.req_wen = 1'b0; bus.req_addr = 32'h8000_0008;
    bus.req_size = 2'b10; bus.req_sext = 1'b0;
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.mem_ready = 1'b1;
    @(posedge clk); #1;
    bus.mem_ready = 1'b0;
    rst_n = 1'b0; #1;
    checks++;
    if ({bus.req_ready, bus.mem_valid, bus.resp_valid, bus.resp_err, bus.resp_rdata} !== '0) begin
      failures++; $display("FAIL rst_wait_outputs got rr=%b mv=%b rv=%b re=%b rd=%h exp all 0",
                           bus.req_ready, bus.mem_valid, bus.resp_valid, bus.resp_err, bus.resp_rdata);
    end
    @(posedge clk); #1; rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({bus.resp_valid, bus.mem_valid, bus.req_ready} !== 3'b001) begin
        failures++; $display("FAIL rst_wait_idle[%0d] got rv=%b mv=%b rr=%b exp 0 0 1",
                             i, bus.resp_valid, bus.mem_valid, bus.req_ready);
      end
    end
    do_txn(1'b0, 32'h8000_0004, 32'h0, 2'b10, 1'b0, 32'hCAFE_F00D, mv, mw, ma, md, mk, rv, re, rd);
    checks++;
    if ({rv, re, rd} !== {1'b1, 1'b0, 32'hCAFE_F00D}) begin
      failures++; $display("FAIL rst_then_lw got rv=%b re=%b rd=%h exp 1 0 cafef00d", rv, re, rd);
    end
  endtask

  task automatic test_timeout();
    bus.req_valid = 1'b1; bus.req_wen = 1'b0; bus.req_addr = 32'h8000_0040;
    bus.req_size = 2'b10; bus.req_sext = 1'b0;
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.mem_ready = 1'b1;
    @(posedge clk); #1;
    bus.mem_ready = 1'b0;
    repeat (254) @(posedge clk);
    #1;
    checks++;
    if (bus.resp_valid !== 1'b0) begin
      failures++; $display("FAIL timeout_early got rv=%b exp 0 after 254 wait cycles", bus.resp_valid);
    end
    @(posedge clk); #1;
    checks++;
    if ({bus.resp_valid, bus.resp_err, bus.resp_rdata} !== {1'b1, 1'b1, 32'h0}) begin
      failures++; $display("FAIL timeout_resp got rv=%b re=%b rd=%h exp 1 1 00000000",
                           bus.resp_valid, bus.resp_err, bus.resp_rdata);
    end
    @(posedge clk); #1;
    checks++;
    if ({bus.resp_valid, bus.req_ready} !== 2'b01) begin
      failures++; $display("FAIL timeout_done got rv=%b rr=%b exp 0 1", bus.resp_valid, bus.req_ready);
    end
  endtask

  initial begin
    #200000;
    failures++;
    $display("FAIL global_timeout got running exp finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "simulation time limit");
  end

  initial begin
    bus.req_valid = 1'b0; bus.req_wen = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.req_size = 2'b00; bus.req_sext = 1'b0; bus.resp_ready = 1'b1;
    bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    test_reset();
    test_loads();
    test_stores();
    test_misalign();
    test_back_pressure();
    test_reset_in_wait();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
